// File: rtl/param_cpu.sv
// Parametrised two-phase (fetch/execute) accumulator-style CPU core with its own
// program memory, register file, ALU and flags, plus a program-load port.
module param_cpu #(
    parameter int DATA_W  = 6,
    parameter int ADDR_W  = 4,
    parameter int REG_AW  = 3,
    localparam int INSTR_W = 4 + 2*REG_AW + DATA_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RUN,
    input  logic               WE,
    input  logic [ADDR_W-1:0]  WA,
    input  logic [INSTR_W-1:0] WD,
    output logic [DATA_W-1:0]  OUTPUT,
    output logic               OUT_VALID,
    output logic               BUSY,
    output logic               HALTED,
    output logic [ADDR_W-1:0]  PC_OUT
);

    localparam int NWORDS = 1 << ADDR_W;
    localparam int NREGS  = 1 << REG_AW;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3,
        OP_OR   = 4'd4,  OP_XOR = 4'd5,  OP_ADDI = 4'd6, OP_MOVI = 4'd7,
        OP_JMP  = 4'd8,  OP_JZ  = 4'd9,  OP_JC  = 4'd10, OP_JN  = 4'd11,
        OP_OUT  = 4'd12, OP_HLT = 4'd13, OP_R14 = 4'd14, OP_R15 = 4'd15
    } opcode_t;

    typedef struct packed {
        opcode_t             op;
        logic [REG_AW-1:0]   rd;
        logic [REG_AW-1:0]   rs;
        logic [DATA_W-1:0]   imm;
    } instr_t;

    state_t                        state;
    instr_t                        ir;
    logic [ADDR_W-1:0]             pc;
    logic [NREGS-1:0][DATA_W-1:0]  regs;
    logic                          cf, zf, sf;
    logic [INSTR_W-1:0]            mem [NWORDS];

    logic [DATA_W-1:0]  a, b, opnd, res;
    logic [DATA_W:0]    sum, diff;
    logic               res_cf, set_flags, wr_reg, taken;
    logic [ADDR_W-1:0]  pc_next;

    // ALU, flag generation and branch resolution for the instruction in ir
    always_comb begin
        a         = regs[ir.rd];
        b         = regs[ir.rs];
        opnd      = (ir.op == OP_ADDI) ? ir.imm : b;
        sum       = {1'b0, a} + {1'b0, opnd};
        diff      = {1'b0, a} - {1'b0, b};
        res       = '0;
        res_cf    = 1'b0;
        set_flags = 1'b0;
        wr_reg    = 1'b0;
        case (ir.op)
            OP_ADD, OP_ADDI: begin
                res = sum[DATA_W-1:0]; res_cf = sum[DATA_W]; set_flags = 1'b1; wr_reg = 1'b1;
            end
            OP_SUB: begin
                res = diff[DATA_W-1:0]; res_cf = diff[DATA_W]; set_flags = 1'b1; wr_reg = 1'b1;
            end
            OP_AND: begin res = a & b; set_flags = 1'b1; wr_reg = 1'b1; end
            OP_OR:  begin res = a | b; set_flags = 1'b1; wr_reg = 1'b1; end
            OP_XOR: begin res = a ^ b; set_flags = 1'b1; wr_reg = 1'b1; end
            OP_MOVI: begin res = ir.imm; wr_reg = 1'b1; end
            default: ;
        endcase

        case (ir.op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = zf;
            OP_JC:   taken = cf;
            OP_JN:   taken = sf;
            default: taken = 1'b0;
        endcase
        pc_next = taken ? ir.imm[ADDR_W-1:0] : pc + ADDR_W'(1);
    end

    // Program memory is deliberately not reset; loads only land while the core is parked.
    always_ff @(posedge CLK) begin
        if (WE && (state == S_IDLE || state == S_HALT))
            mem[WA] <= WD;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            regs <= '0;
            cf   <= 1'b0;
            zf   <= 1'b0;
            sf   <= 1'b0;
        end else if (state == S_EXEC) begin
            if (wr_reg)
                regs[ir.rd] <= res;
            if (set_flags) begin
                cf <= res_cf;
                zf <= (res == '0);
                sf <= res[DATA_W-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            OUTPUT    <= '0;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            HALTED    <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (RUN) begin
                        state <= S_FETCH;
                        BUSY  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir    <= instr_t'(mem[pc]);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // HLT leaves PC pointing at itself
                    if (ir.op == OP_HLT) begin
                        state  <= S_HALT;
                        BUSY   <= 1'b0;
                        HALTED <= 1'b1;
                    end else begin
                        pc <= pc_next;
                        if (ir.op == OP_OUT) begin
                            OUTPUT    <= a;
                            OUT_VALID <= 1'b1;
                        end
                        if (RUN) begin
                            state <= S_FETCH;
                        end else begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end
                end
                S_HALT: begin
                    if (!RUN) begin
                        state  <= S_IDLE;
                        HALTED <= 1'b0;
                        pc     <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign PC_OUT = pc;

endmodule

// File: tb/tb_param_cpu.sv
// Self-checking bench for param_cpu: an instruction-level model stepped on the
// documented two-edge-per-instruction timing, plus hand-computed checks.
module tb_param_cpu;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RUN, WE;
    logic [3:0]  WA;
    logic [15:0] WD;
    logic [5:0]  OUTPUT;
    logic        OUT_VALID, BUSY, HALTED;
    logic [3:0]  PC_OUT;

    param_cpu #(.DATA_W(6), .ADDR_W(4), .REG_AW(3)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .WE(WE), .WA(WA), .WD(WD),
        .OUTPUT(OUTPUT), .OUT_VALID(OUT_VALID), .BUSY(BUSY),
        .HALTED(HALTED), .PC_OUT(PC_OUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;
    int obs_q[$];
    logic [15:0] prog [16];

    // model: ISA state plus a run mode (0 parked, 1 running, 2 halted)
    int m_mem [16];
    int m_reg [8];
    int m_cf, m_zf, m_sf, m_pc, m_out, m_ov, m_mode, m_ec;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic logic [15:0] ins(input int op, input int rd, input int rs, input int imm);
        return 16'((op << 12) | (rd << 9) | (rs << 6) | (imm & 63));
    endfunction

    function automatic void m_reset();
        foreach (m_reg[i]) m_reg[i] = 0;
        m_cf = 0; m_zf = 0; m_sf = 0; m_pc = 0;
        m_out = 0; m_ov = 0; m_mode = 0; m_ec = 0;
    endfunction

    function automatic void m_exec();
        int w, op, rd, rs, imm, a, b, r;
        bit flg;
        w = m_mem[m_pc];
        op = (w >> 12) & 15; rd = (w >> 9) & 7; rs = (w >> 6) & 7; imm = w & 63;
        a = m_reg[rd]; b = m_reg[rs]; r = 0; flg = 1;
        case (op)
            1: begin r = a + b;   m_cf = (r > 63); end
            2: begin r = a - b;   m_cf = (a < b);  end
            3: begin r = a & b;   m_cf = 0; end
            4: begin r = a | b;   m_cf = 0; end
            5: begin r = a ^ b;   m_cf = 0; end
            6: begin r = a + imm; m_cf = (r > 63); end
            default: flg = 0;
        endcase
        if (flg) begin
            r = r & 63;
            m_reg[rd] = r;
            m_zf = (r == 0);
            m_sf = (r >= 32);
        end
        if (op == 7) m_reg[rd] = imm;
        if (op == 13) begin
            m_mode = 2;
        end else begin
            if (op == 8 || (op == 9 && m_zf != 0) || (op == 10 && m_cf != 0) || (op == 11 && m_sf != 0))
                m_pc = imm % 16;
            else
                m_pc = (m_pc + 1) % 16;
            if (op == 12) begin m_out = a; m_ov = 1; end
        end
    endfunction

    // one clock edge of the model: instruction k of a run executes at edge 2k+2
    function automatic void m_edge(input bit run, input bit we, input int wa, input int wd);
        m_ov = 0;
        case (m_mode)
            0: begin
                if (we) m_mem[wa] = wd;
                if (run) begin m_mode = 1; m_ec = 0; end
            end
            2: begin
                if (we) m_mem[wa] = wd;
                if (!run) begin m_mode = 0; m_pc = 0; end
            end
            default: begin
                m_ec++;
                if (m_ec % 2 == 0) begin
                    m_exec();
                    if (m_mode == 1 && !run) m_mode = 0;
                end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (!RST) m_edge(RUN, WE, int'(WA), int'(WD));
        #1;
    endtask

    always @(negedge CLK) begin
        if (cmp_en && !RST) begin
            chk("pc", int'(PC_OUT), m_pc);
            chk("busy", int'(BUSY), int'(m_mode == 1));
            chk("halted", int'(HALTED), int'(m_mode == 2));
            chk("out_valid", int'(OUT_VALID), m_ov);
            chk("output", int'(OUTPUT), m_out);
            if (OUT_VALID) obs_q.push_back(int'(OUTPUT));
        end
    end

    task automatic do_reset(input string nm);
        RUN = 0; WE = 0;
        RST = 1;
        #1;
        m_reset();
        chk({nm, "_rst_output"}, int'(OUTPUT), 0);
        chk({nm, "_rst_ovalid"}, int'(OUT_VALID), 0);
        chk({nm, "_rst_busy"}, int'(BUSY), 0);
        chk({nm, "_rst_halted"}, int'(HALTED), 0);
        chk({nm, "_rst_pc"}, int'(PC_OUT), 0);
        tick();
        RST = 0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 16'h0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) begin
            WE = 1; WA = 4'(i); WD = prog[i];
            tick();
        end
        WE = 0;
    endtask

    task automatic run_prog(input string nm);
        int n;
        n = 0;
        RUN = 1;
        while (m_mode != 2 && n < 300) begin tick(); n++; end
        chk({nm, "_halted"}, int'(HALTED), 1);
        RUN = 0;
        tick();
        chk({nm, "_idle_pc"}, int'(PC_OUT), 0);
    endtask

    task automatic check_obs(input string nm, input int n, input int v0, input int v1, input int v2);
        int v[3];
        v[0] = v0; v[1] = v1; v[2] = v2;
        chk({nm, "_count"}, obs_q.size(), n);
        for (int i = 0; i < n && i < obs_q.size(); i++)
            chk($sformatf("%s_out%0d", nm, i), obs_q[i], v[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        RUN = 0; WE = 0; WA = 0; WD = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
        do_reset("init");
        cmp_en = 1;

        // T1: 5+3 with exact edge timing
        clear_prog();
        prog[0] = ins(7, 1, 0, 5); prog[1] = ins(7, 2, 0, 3); prog[2] = ins(1, 1, 2, 0);
        prog[3] = ins(12, 1, 0, 0); prog[4] = ins(13, 0, 0, 0);
        load_all();
        obs_q.delete();
        RUN = 1;
        for (int e = 0; e <= 8; e++) tick();
        chk("t1_ovalid_e8", int'(OUT_VALID), 1);
        chk("t1_output_e8", int'(OUTPUT), 8);
        tick();
        chk("t1_ovalid_e9", int'(OUT_VALID), 0);
        chk("t1_halted_e9", int'(HALTED), 0);
        tick();
        chk("t1_halted_e10", int'(HALTED), 1);
        chk("t1_pc_e10", int'(PC_OUT), 4);
        chk("t1_busy_e10", int'(BUSY), 0);
        RUN = 0;
        tick();
        chk("t1_idle_pc", int'(PC_OUT), 0);
        check_obs("t1", 1, 8, 0, 0);

        // T2: 63+1 wraps to 0 with CF=1, ZF=1, SF=0
        clear_prog();
        prog[0] = ins(7, 1, 0, 63); prog[1] = ins(6, 1, 0, 1);  prog[2] = ins(9, 0, 0, 5);
        prog[3] = ins(7, 1, 0, 7);  prog[4] = ins(12, 1, 0, 0); prog[5] = ins(12, 1, 0, 0);
        prog[6] = ins(10, 0, 0, 8); prog[7] = ins(13, 0, 0, 0); prog[8] = ins(11, 0, 0, 10);
        prog[9] = ins(7, 4, 0, 42); prog[10] = ins(12, 4, 0, 0); prog[11] = ins(13, 0, 0, 0);
        load_all();
        obs_q.delete();
        run_prog("t2");
        check_obs("t2", 2, 0, 42, 0);

        // T3: 2-3 borrows to 63 with CF=1, SF=1
        clear_prog();
        prog[0] = ins(7, 1, 0, 2);  prog[1] = ins(7, 2, 0, 3);  prog[2] = ins(2, 1, 2, 0);
        prog[3] = ins(11, 0, 0, 6); prog[4] = ins(12, 2, 0, 0); prog[5] = ins(13, 0, 0, 0);
        prog[6] = ins(12, 1, 0, 0); prog[7] = ins(10, 0, 0, 9); prog[8] = ins(13, 0, 0, 0);
        prog[9] = ins(12, 2, 0, 0); prog[10] = ins(13, 0, 0, 0);
        load_all();
        obs_q.delete();
        run_prog("t3");
        check_obs("t3", 2, 63, 3, 0);

        // T4: NOP sled wraps PC; a write attempted while busy must not land
        clear_prog();
        load_all();
        RUN = 1;
        tick();
        for (int e = 1; e <= 32; e++) tick();
        chk("t4_pc_wrapped", int'(PC_OUT), 0);
        chk("t4_busy", int'(BUSY), 1);
        WE = 1; WA = 4'd0; WD = ins(13, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        WE = 0;
        for (int i = 0; i < 40; i++) tick();
        chk("t4_not_halted", int'(HALTED), 0);
        RUN = 0;
        tick(); tick();
        chk("t4_stop_busy", int'(BUSY), 0);
        chk("t4_stop_pc", int'(PC_OUT), 7);

        // T5: pause mid-program, then resume
        do_reset("t5");
        clear_prog();
        prog[0] = ins(7, 1, 0, 1); prog[1] = ins(12, 1, 0, 0); prog[2] = ins(6, 1, 0, 1);
        prog[3] = ins(12, 1, 0, 0); prog[4] = ins(6, 1, 0, 1); prog[5] = ins(12, 1, 0, 0);
        prog[6] = ins(13, 0, 0, 0);
        load_all();
        obs_q.delete();
        RUN = 1;
        for (int e = 0; e <= 4; e++) tick();
        RUN = 0;
        tick(); tick();
        chk("t5_pause_busy", int'(BUSY), 0);
        chk("t5_pause_pc", int'(PC_OUT), 3);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_pause_pc_held", int'(PC_OUT), 3);
        run_prog("t5");
        check_obs("t5", 3, 1, 2, 3);

        // T6: reset during EXEC of ADD, then rerun from retained memory
        clear_prog();
        prog[0] = ins(7, 1, 0, 5); prog[1] = ins(7, 2, 0, 3); prog[2] = ins(1, 1, 2, 0);
        prog[3] = ins(12, 1, 0, 0); prog[4] = ins(13, 0, 0, 0);
        load_all();
        obs_q.delete();
        RUN = 1;
        for (int e = 0; e <= 5; e++) tick();
        chk("t6_busy_pre", int'(BUSY), 1);
        do_reset("t6");
        check_obs("t6_abandon", 0, 0, 0, 0);
        obs_q.delete();
        RUN = 1;
        while (m_mode != 2) tick();
        chk("t6_rerun_pc", int'(PC_OUT), 4);
        check_obs("t6_rerun", 1, 8, 0, 0);
        // write accepted while halted: OUT r2 replaces OUT r1
        WE = 1; WA = 4'd3; WD = ins(12, 2, 0, 0);
        tick();
        WE = 0;
        RUN = 0;
        tick();
        obs_q.delete();
        run_prog("t6b");
        check_obs("t6b", 1, 3, 0, 0);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_cpu.md
# param_cpu

Parametrised multi-cycle accumulator-style CPU core. It is the next generation of the 6-bit CPU: data width, program depth and register count are generics, and it adds an explicit fetch/execute state machine, a program-load port, conditional branches on the flag register, an output strobe, pause and halt. It sits at the top of the CPU hierarchy. It owns its program memory, register file, ALU and flag register, and is loaded through the write port while idle.

## Interface
- DATA_W, 6: datapath, register and immediate width.
- ADDR_W, 4: program address width, giving 2^ADDR_W instruction words. Must satisfy ADDR_W <= DATA_W.
- REG_AW, 3: register index width, giving 2^REG_AW registers.
- Derived INSTR_W = 4 + 2*REG_AW + DATA_W (16 by default). Field layout, MSB first: OP[4], RD[REG_AW], RS[REG_AW], IMM[DATA_W].

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- RUN  in  1  level; high = execute, low = pause at the next instruction boundary.
- WE  in  1  program-memory write enable.
- WA  in  ADDR_W  program write address.
- WD  in  INSTR_W  program write data.
- OUTPUT  out  DATA_W  last value emitted by OUT.
- OUT_VALID  out  1  one-cycle pulse when OUTPUT updates.
- BUSY  out  1  high in FETCH or EXEC.
- HALTED  out  1  high in HALT.
- PC_OUT  out  ADDR_W  current program counter.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 ADD: RD = RD + RS.
  - 2 SUB: RD = RD - RS.
  - 3 AND, 4 OR, 5 XOR: RD = RD op RS.
  - 6 ADDI: RD = RD + IMM.
  - 7 MOVI: RD = IMM.
  - 8 JMP: PC = IMM[ADDR_W-1:0].
  - 9 JZ, 10 JC, 11 JN: jump if ZF, CF or SF respectively is set.
  - 12 OUT: OUTPUT = RD.
  - 13 HLT.
  - 14-15 behave as NOP.
- Arithmetic is modulo 2^DATA_W.
- Flags:
  - CF on ADD/ADDI is the carry out of bit DATA_W-1. On SUB, CF is the borrow (RD < RS unsigned). AND/OR/XOR clear CF.
  - ZF = (result == 0). SF = result MSB.
  - Flags are written only by opcodes 1-6. All other opcodes leave them unchanged.
- Branches test flags registered by earlier instructions.
- All registers, including index 0, are general purpose and writable.
- PC increments by 1 for every non-taken instruction and wraps from 2^ADDR_W-1 to 0.
- Program memory writes are accepted only in IDLE or HALT. WE in FETCH or EXEC is ignored.
- State machine:
  - IDLE → FETCH when RUN=1.
  - FETCH → EXEC unconditionally; the instruction register loads mem[PC].
  - EXEC → HALT if the opcode is HLT.
  - EXEC → FETCH if RUN=1, otherwise EXEC → IDLE. PC, registers and flags are retained, so RUN=1 resumes at PC.
  - HALT holds while RUN=1. HALT → IDLE when RUN=0, and PC clears to 0 on that transition.
- Reset, including mid-instruction:
  - State IDLE; PC=0; all registers and flags = 0.
  - OUTPUT=0, OUT_VALID=0, BUSY=0, HALTED=0.
  - Program memory contents are not reset.
  - An instruction in flight is abandoned with no register or flag write.

## Timing
- Two cycles per instruction, FETCH then EXEC, with no stalls.
- RUN sampled high at edge 0 in IDLE:
  - Instruction k executes at edge 2k+2.
  - Register, flag, PC and OUTPUT updates are visible after that edge.
- OUT_VALID is high for exactly the one cycle following an OUT's EXEC edge.
- HALTED rises after the HLT's EXEC edge.
- A write to mem[A] in IDLE is fetchable at the next FETCH.
- RUN dropping during FETCH still completes that instruction; the core enters IDLE after its EXEC.
- All outputs are registered. BUSY = state ∈ {FETCH, EXEC}.

## Test plan
- Program MOVI r1,5; MOVI r2,3; ADD r1,r2; OUT r1; HLT, then RUN=1 → OUTPUT=8 with OUT_VALID high for one cycle after edge 8, HALTED=1 after edge 10, PC_OUT=4.
- MOVI r1,63; ADDI r1,1; JZ 5 … at 5: OUT r1 → branch taken; r1=0, CF=1, ZF=1, SF=0; OUTPUT=0.
- MOVI r1,2; MOVI r2,3; SUB r1,r2; JN 6 … at 6: OUT r1 → OUTPUT=63, CF=1, SF=1.
- Sixteen NOPs with RUN held → PC_OUT goes 15 → 0, and execution continues; WE asserted while BUSY=1 leaves memory unchanged, checked by readback of program behaviour.
- RUN dropped mid-program → the current instruction completes, BUSY=0, PC is held; RUN reasserted → the remaining outputs match an uninterrupted run.
- RST pulsed during EXEC of ADD → no register write occurs; all outputs are 0 and the state is IDLE immediately after RST, asynchronously.
